// File: rtl/flag_shadow_stack_pkg.sv
// Shared definitions for the RAT status-flag register and its interrupt shadow stack.
// Flag bit positions, the default flag vector type and the stack-operation decode.
package rat_flag_pkg;

   localparam int FLG_C_IDX = 0;
   localparam int FLG_Z_IDX = 1;
   localparam int DEF_NUM_FLAGS = 2;

   typedef logic [DEF_NUM_FLAGS-1:0] flags_t;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_PUSH = 2'd1,
      OP_POP  = 2'd2,
      OP_XCHG = 2'd3
   } stack_op_e;

   // Interrupt entry pushes, RETI pops; both together swap the current flags with the top entry.
   function automatic stack_op_e decode_op(input logic shad_ld, input logic ld_sel);
      stack_op_e op;
      op = OP_NONE;
      if (shad_ld && ld_sel) begin
         op = OP_XCHG;
      end else if (shad_ld) begin
         op = OP_PUSH;
      end else if (ld_sel) begin
         op = OP_POP;
      end
      return op;
   endfunction

endpackage

// File: rtl/flag_shadow_stack_if.sv
// Bus between the ALU/control unit and the flag shadow stack.
// The master drives flag and stack controls; the slave returns flags and stack status.
interface flag_shadow_stack_if #(
   parameter int NUM_FLAGS = 2,
   parameter int DEPTH     = 4
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [NUM_FLAGS-1:0] FLAGS_IN;
   logic [NUM_FLAGS-1:0] FLG_LD;
   logic [NUM_FLAGS-1:0] FLG_SET;
   logic [NUM_FLAGS-1:0] FLG_CLR;
   logic                 FLG_SHAD_LD;
   logic                 FLG_LD_SEL;
   logic [NUM_FLAGS-1:0] FLAGS_OUT;
   logic [NUM_FLAGS-1:0] SHAD_TOP;
   logic [CNT_W-1:0]     SHAD_CNT;
   logic                 SHAD_OVF;
   logic                 SHAD_UNF;

   modport master (
      output FLAGS_IN, FLG_LD, FLG_SET, FLG_CLR, FLG_SHAD_LD, FLG_LD_SEL,
      input  FLAGS_OUT, SHAD_TOP, SHAD_CNT, SHAD_OVF, SHAD_UNF
   );

   modport slave (
      input  FLAGS_IN, FLG_LD, FLG_SET, FLG_CLR, FLG_SHAD_LD, FLG_LD_SEL,
      output FLAGS_OUT, SHAD_TOP, SHAD_CNT, SHAD_OVF, SHAD_UNF
   );

endinterface

// File: rtl/flag_shadow_stack_flag_bit_reg.sv
// One status-flag bit: a valid restore from the shadow stack beats CLR, then SET, then LD.
module flag_bit_reg (
   input  logic clk,
   input  logic rst,
   input  logic restore,
   input  logic restore_val,
   input  logic clr,
   input  logic set,
   input  logic ld,
   input  logic ld_val,
   output logic q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= 1'b0;
      end else if (restore) begin
         q <= restore_val;
      end else if (clr) begin
         q <= 1'b0;
      end else if (set) begin
         q <= 1'b1;
      end else if (ld) begin
         q <= ld_val;
      end
   end

endmodule

// File: rtl/flag_shadow_stack.sv
// Status flags with per-bit set/clear/load plus a LIFO shadow stack that saves the
// flags on interrupt entry and restores them on RETI, allowing nested interrupts.
module flag_shadow_stack #(
   parameter int NUM_FLAGS = 2,
   parameter int DEPTH     = 4
) (
   input  logic              CLK,
   input  logic              RST,
   flag_shadow_stack_if.slave bus
);

   import rat_flag_pkg::*;

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [NUM_FLAGS-1:0] flags_q;
   logic [NUM_FLAGS-1:0] stack_mem [DEPTH];
   logic [NUM_FLAGS-1:0] mem_next  [DEPTH];
   logic [NUM_FLAGS-1:0] top_q;
   logic [NUM_FLAGS-1:0] restore_val;
   logic [CNT_W-1:0]     cnt_q;
   logic [CNT_W-1:0]     cnt_next;
   logic [IDX_W-1:0]     push_idx;
   logic [IDX_W-1:0]     top_idx;
   logic [IDX_W-1:0]     next_top_idx;
   logic                 ovf_q;
   logic                 unf_q;
   stack_op_e            op;
   logic                 empty;
   logic                 full;
   logic                 do_push;
   logic                 do_pop;
   logic                 do_xchg;
   logic                 restore;

   // An exchange on an empty stack degrades to a plain push; an exchange on a full stack is legal.
   always_comb begin
      op          = decode_op(bus.FLG_SHAD_LD, bus.FLG_LD_SEL);
      empty       = (cnt_q == '0);
      full        = (cnt_q == CNT_FULL);
      push_idx    = IDX_W'(cnt_q);
      top_idx     = IDX_W'(cnt_q - CNT_ONE);
      do_push     = ((op == OP_PUSH) || ((op == OP_XCHG) && empty)) && !full;
      do_pop      = (op == OP_POP) && !empty;
      do_xchg     = (op == OP_XCHG) && !empty;
      restore     = do_pop || do_xchg;
      restore_val = stack_mem[top_idx];
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_next[i] = stack_mem[i];
      end
      cnt_next = cnt_q;
      if (do_push) begin
         mem_next[push_idx] = flags_q;
         cnt_next           = cnt_q + CNT_ONE;
      end
      if (do_pop) begin
         cnt_next = cnt_q - CNT_ONE;
      end
      if (do_xchg) begin
         mem_next[top_idx] = flags_q;
      end
      next_top_idx = IDX_W'(cnt_next - CNT_ONE);
   end

   // SHAD_TOP is registered from the post-edge stack so it tracks SHAD_CNT exactly.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            stack_mem[i] <= '0;
         end
         cnt_q <= '0;
         top_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            stack_mem[i] <= mem_next[i];
         end
         cnt_q <= cnt_next;
         top_q <= (cnt_next == '0) ? '0 : mem_next[next_top_idx];
         if ((op == OP_PUSH) && full) begin
            ovf_q <= 1'b1;
         end
         if ((op == OP_POP) && empty) begin
            unf_q <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NUM_FLAGS; i++) begin : g_flag
      flag_bit_reg u_bit (
         .clk         (CLK),
         .rst         (RST),
         .restore     (restore),
         .restore_val (restore_val[i]),
         .clr         (bus.FLG_CLR[i]),
         .set         (bus.FLG_SET[i]),
         .ld          (bus.FLG_LD[i]),
         .ld_val      (bus.FLAGS_IN[i]),
         .q           (flags_q[i])
      );
   end

   assign bus.FLAGS_OUT = flags_q;
   assign bus.SHAD_TOP  = top_q;
   assign bus.SHAD_CNT  = cnt_q;
   assign bus.SHAD_OVF  = ovf_q;
   assign bus.SHAD_UNF  = unf_q;

endmodule

// File: tb/tb_flag_shadow_stack.sv
// Directed bench for flag_shadow_stack: priority, nesting, overflow/underflow, exchange, reset.
module tb_flag_shadow_stack;

   import rat_flag_pkg::*;

   logic CLK;
   logic RST;
   int   errors;
   int   checks;

   flag_shadow_stack_if #(.NUM_FLAGS(2), .DEPTH(4)) bus ();

   flag_shadow_stack #(.NUM_FLAGS(2), .DEPTH(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   flags_t ovf_ld    [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
   int     ovf_cnt   [5] = '{1, 2, 3, 4, 4};
   flags_t ovf_top   [5] = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b10};
   flags_t rst_flags [4] = '{2'b10, 2'b01, 2'b00, 2'b11};
   int     rst_cnt   [4] = '{3, 2, 1, 0};
   flags_t rst_top   [4] = '{2'b01, 2'b00, 2'b11, 2'b00};

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic expectState(input string tag, input flags_t f, input int c, input flags_t t,
                              input logic o, input logic u);
      checkOutput({tag, ".flags"}, 32'(bus.FLAGS_OUT), 32'(f));
      checkOutput({tag, ".cnt"},   32'(bus.SHAD_CNT),  32'(c));
      checkOutput({tag, ".top"},   32'(bus.SHAD_TOP),  32'(t));
      checkOutput({tag, ".ovf"},   32'(bus.SHAD_OVF),  32'(o));
      checkOutput({tag, ".unf"},   32'(bus.SHAD_UNF),  32'(u));
   endtask

   // Drive on the falling edge, let one rising edge pass, then sample 1 time unit later.
   task automatic applyStimulus(input flags_t fin, input flags_t ld, input flags_t set,
                                input flags_t clr, input logic push, input logic pop);
      @(negedge CLK);
      bus.FLAGS_IN    = fin;
      bus.FLG_LD      = ld;
      bus.FLG_SET     = set;
      bus.FLG_CLR     = clr;
      bus.FLG_SHAD_LD = push;
      bus.FLG_LD_SEL  = pop;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      RST = 1'b1;
      bus.FLAGS_IN = '0;
      bus.FLG_LD = '0;
      bus.FLG_SET = '0;
      bus.FLG_CLR = '0;
      bus.FLG_SHAD_LD = 1'b0;
      bus.FLG_LD_SEL = 1'b0;

      applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
      expectState("reset", 2'b00, 0, 2'b00, 1'b0, 1'b0);
      RST = 1'b0;

      applyStimulus(2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
      expectState("load11", 2'b11, 0, 2'b00, 1'b0, 1'b0);

      applyStimulus(2'b00, 2'b11, 2'b11, 2'b01, 1'b0, 1'b0);
      checkOutput("priority", 32'(bus.FLAGS_OUT), 32'(2'b10));
      checkOutput("priority.c", 32'(bus.FLAGS_OUT[FLG_C_IDX]), 32'd0);
      checkOutput("priority.z", 32'(bus.FLAGS_OUT[FLG_Z_IDX]), 32'd1);

      applyStimulus(2'b01, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
      applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
      expectState("nest.push1", 2'b01, 1, 2'b01, 1'b0, 1'b0);
      applyStimulus(2'b10, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
      applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
      expectState("nest.push2", 2'b10, 2, 2'b10, 1'b0, 1'b0);
      applyStimulus(2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
      checkOutput("nest.load00", 32'(bus.FLAGS_OUT), 32'(2'b00));
      applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
      expectState("nest.pop1", 2'b10, 1, 2'b01, 1'b0, 1'b0);
      applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
      expectState("nest.pop2", 2'b01, 0, 2'b00, 1'b0, 1'b0);

      applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
      expectState("unf.plain", 2'b01, 0, 2'b00, 1'b0, 1'b1);
      applyStimulus(2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1);
      expectState("unf.fallthru", 2'b11, 0, 2'b00, 1'b0, 1'b1);

      // Each push also loads a new value, so the stack must capture the pre-edge flags.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(ovf_ld[i], 2'b11, 2'b00, 2'b00, 1'b1, 1'b0);
         expectState($sformatf("ovf.push%0d", i), ovf_ld[i], ovf_cnt[i], ovf_top[i], (i == 4), 1'b1);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1);
         expectState($sformatf("ovf.pop%0d", i), rst_flags[i], rst_cnt[i], rst_top[i], 1'b1, 1'b1);
      end

      applyStimulus(2'b01, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
      applyStimulus(2'b10, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0);
      expectState("xchg.setup", 2'b10, 1, 2'b01, 1'b1, 1'b1);
      applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
      expectState("xchg", 2'b01, 1, 2'b10, 1'b1, 1'b1);

      applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
      applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
      expectState("midrst.pre", 2'b01, 3, 2'b01, 1'b1, 1'b1);
      RST = 1'b1;
      applyStimulus(2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0);
      expectState("midrst", 2'b00, 0, 2'b00, 1'b0, 1'b0);
      RST = 1'b0;
      applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
      expectState("midrst.unf", 2'b00, 0, 2'b00, 1'b0, 1'b1);

      RST = 1'b1;
      applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
      RST = 1'b0;
      applyStimulus(2'b10, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
      applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
      expectState("xchg.empty", 2'b10, 1, 2'b10, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/flag_shadow_stack.md
Name: flag_shadow_stack

Overview:
- Parametrised successor to the single-bit C-flag load-select mux.
- Holds the CPU status flags (C, Z, extensible) as registers with per-flag set/clear/load control.
- Adds a DEPTH-entry shadow stack: flags are pushed on interrupt entry and restored on RETI, so nested interrupts are supported.
- Sits between the ALU flag outputs and the control unit / branch logic in the RAT datapath.

Parameters:
- NUM_FLAGS, 2, number of flag bits (bit 0 = C, bit 1 = Z, higher bits are spare flags).
- DEPTH, 4, number of shadow-stack entries (at least 1).
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- FLAGS_IN  in  NUM_FLAGS  flag values from the ALU.
- FLG_LD  in  NUM_FLAGS  per-flag load enable from FLAGS_IN.
- FLG_SET  in  NUM_FLAGS  per-flag set to 1.
- FLG_CLR  in  NUM_FLAGS  per-flag clear to 0.
- FLG_SHAD_LD  in  1  push current flags onto the shadow stack (interrupt entry).
- FLG_LD_SEL  in  1  restore flags from the stack top and pop (RETI).
- FLAGS_OUT  out  NUM_FLAGS  registered flag values.
- SHAD_TOP  out  NUM_FLAGS  current top-of-stack entry; 0 when the stack is empty.
- SHAD_CNT  out  CNT_W  number of valid stack entries.
- SHAD_OVF  out  1  sticky flag: a push was attempted while the stack was full.
- SHAD_UNF  out  1  sticky flag: a restore was attempted while the stack was empty.

Behaviour:
- Reset:
  - Applies in the cycle RST is high.
  - FLAGS_OUT=0, SHAD_CNT=0, SHAD_OVF=0, SHAD_UNF=0, all stack entries=0.
  - RST overrides every other input.
- Per-flag next value, highest priority first:
  1. Valid restore: the stack-top bit.
  2. FLG_CLR[i]: 0.
  3. FLG_SET[i]: 1.
  4. FLG_LD[i]: FLAGS_IN[i].
  5. Otherwise: hold.
- Latency:
  - All flag updates are visible on FLAGS_OUT one cycle after the controlling edge.
  - SHAD_TOP and SHAD_CNT are also registered, so they change one cycle after a push or pop.
- Push (FLG_SHAD_LD=1, FLG_LD_SEL=0, SHAD_CNT<DEPTH):
  - Writes the pre-edge FLAGS_OUT into entry SHAD_CNT, then SHAD_CNT+1.
  - Flag updates from SET/CLR/LD in the same cycle still apply to FLAGS_OUT.
- Push when full (SHAD_CNT==DEPTH):
  - Stack unchanged, SHAD_OVF <= 1.
  - Flag updates still apply.
- Restore (FLG_LD_SEL=1, FLG_SHAD_LD=0, SHAD_CNT>0):
  - FLAGS_OUT <= entry[SHAD_CNT-1], then SHAD_CNT-1.
  - SET/CLR/LD are ignored in that cycle.
- Restore when empty:
  - SHAD_UNF <= 1, SHAD_CNT stays 0.
  - The flag update falls through to the CLR/SET/LD rules.
- Push and restore in the same cycle with SHAD_CNT>0 (exchange):
  - FLAGS_OUT <= entry[SHAD_CNT-1].
  - entry[SHAD_CNT-1] <= pre-edge FLAGS_OUT.
  - SHAD_CNT unchanged.
- Push and restore in the same cycle with SHAD_CNT==0:
  - Treated as a plain push; SHAD_UNF is not set.
- Sticky flags: SHAD_OVF and SHAD_UNF clear only on RST.
- Stack organisation: LIFO with no wrap-around; entries at or above SHAD_CNT are don't-care internally.
- With the default parameters and FLG_SHAD_LD tied low, the C path behaves as the legacy C-flag register with load select.

Decomposition:
- Shared package rat_flag_pkg holds:
  - localparams FLG_C_IDX=0 and FLG_Z_IDX=1;
  - typedef flags_t = logic [NUM_FLAGS-1:0] at the default width;
  - an enum for the stack operation (NONE, PUSH, POP, XCHG), decoded from FLG_SHAD_LD and FLG_LD_SEL.
- One natural sub-module, flag_bit_reg: a single flag bit with restore/CLR/SET/LD priority.
  - Instantiated NUM_FLAGS times via generate.
- The stack and count logic live in the top module.

Test Plan:
- Reset then load: RST=1 then release, FLAGS_IN=2'b11, FLG_LD=2'b11 -> FLAGS_OUT=2'b11 next cycle, SHAD_CNT=0.
- Priority: FLG_CLR=2'b01, FLG_SET=2'b11, FLG_LD=2'b11, FLAGS_IN=2'b00 -> FLAGS_OUT=2'b10.
- Nested push/restore:
  - Stimulus: flags 2'b01 then push; set flags to 2'b10 then push; load 2'b00; restore; restore.
  - Response: FLAGS_OUT=2'b10 then 2'b01; SHAD_CNT steps 1,2,1,0.
- Overflow (DEPTH=4): five pushes -> SHAD_CNT=4, SHAD_OVF=1; four restores return the first four pushed values in reverse order.
- Underflow and exchange:
  - Restore at SHAD_CNT=0 -> SHAD_UNF=1, flags unchanged.
  - Push+restore together with top=2'b01 and flags=2'b10 -> FLAGS_OUT=2'b01, SHAD_TOP=2'b10, SHAD_CNT unchanged.
- Reset mid-operation: with SHAD_CNT=3 and SHAD_OVF=1, assert RST for 1 cycle alongside a push -> all outputs 0, and the next restore sets SHAD_UNF.
